// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl -- keypad sequencing controller for the calculator datapath.
// Collects two decimal operands of up to MAX_DIGITS digits from one-cycle key
// strobes, drives them in binary to the adder/subtractor, selects sum or
// difference, enables the result path, and shows the operand being typed as
// BCD digits. All outputs are registered: they change the cycle after a strobe.
// Optional build macro: CALC_CHAIN_EN -- when defined, '+'/'-' while a result
// is shown chains that result in as operand A of a new operation.
module calc_seq_ctrl #(
    parameter int MAX_DIGITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [13:0] op_a_bin,
    output logic [13:0] op_b_bin,
    output logic        operator,
    output logic        is_res,
    output logic [3:0]  entry_d3,
    output logic [3:0]  entry_d2,
    output logic [3:0]  entry_d1,
    output logic [3:0]  entry_d0,
    output logic        res_neg,
    output logic        key_err,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        ENTER_A  = 2'b00,
        ENTER_B  = 2'b01,
        SHOW_RES = 2'b10
    } state_t;

    localparam logic [3:0] KEY_PLUS  = 4'd10;
    localparam logic [3:0] KEY_MINUS = 4'd11;
    localparam logic [3:0] KEY_EQ    = 4'd12;
    localparam logic [3:0] KEY_CLR   = 4'd13;
    localparam logic [2:0] MAX_CNT   = 3'(MAX_DIGITS);

    state_t          state_q, state_d;
    logic [13:0]     op_a_q, op_a_d;
    logic [13:0]     op_b_q, op_b_d;
    logic            operator_q, operator_d;
    logic            is_res_q, is_res_d;
    logic            res_neg_q, res_neg_d;
    logic            key_err_q, key_err_d;
    logic [3:0][3:0] entry_q, entry_d;   // [3] is the most significant digit
    logic [2:0]      cnt_q, cnt_d;

    // Key decode and the "append one decimal digit" arithmetic. The digit
    // count limit keeps operand*10 + digit within 14 bits.
    logic        is_digit, is_op, is_eq, is_clr, op_is_plus;
    logic [13:0] digit_ext, op_a_append, op_b_append;

    assign is_digit    = (key_code <= 4'd9);
    assign is_op       = (key_code == KEY_PLUS) || (key_code == KEY_MINUS);
    assign is_eq       = (key_code == KEY_EQ);
    assign is_clr      = (key_code == KEY_CLR);
    assign op_is_plus  = (key_code == KEY_PLUS);
    assign digit_ext   = {10'd0, key_code};
    assign op_a_append = op_a_q * 14'd10 + digit_ext;
    assign op_b_append = op_b_q * 14'd10 + digit_ext;

`ifdef CALC_CHAIN_EN
    // Result of the operation currently shown, for chaining into operand A.
    // One extra bit catches sum overflow; a difference is legal only if A >= B.
    localparam logic [14:0] RES_MAX = 15'd9999;
    logic [14:0] chain_val;
    logic        chain_ok;

    assign chain_val = operator_q ? ({1'b0, op_a_q} + {1'b0, op_b_q})
                                  : ({1'b0, op_a_q} - {1'b0, op_b_q});
    assign chain_ok  = operator_q ? (chain_val <= RES_MAX) : (op_a_q >= op_b_q);
`endif

    // State register: every controller register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ENTER_A;
            op_a_q     <= '0;
            op_b_q     <= '0;
            operator_q <= 1'b1;
            is_res_q   <= 1'b0;
            res_neg_q  <= 1'b0;
            key_err_q  <= 1'b0;
            entry_q    <= '0;
            cnt_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values of the others, independent of statement order.
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            operator_q <= operator_d;
            is_res_q   <= is_res_d;
            res_neg_q  <= res_neg_d;
            key_err_q  <= key_err_d;
            entry_q    <= entry_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state logic: reaction of the controller to one key strobe.
    always_comb begin
        // NOTE: every next value defaults to its held value (key_err to 0)
        // before any branch, so no path leaves one unassigned and no latch is
        // inferred.
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        operator_d = operator_q;
        is_res_d   = is_res_q;
        res_neg_d  = res_neg_q;
        key_err_d  = 1'b0;
        entry_d    = entry_q;
        cnt_d      = cnt_q;

        if (key_valid) begin
            if (is_clr) begin
                // Clear returns to the reset values without flagging an error.
                state_d    = ENTER_A;
                op_a_d     = '0;
                op_b_d     = '0;
                operator_d = 1'b1;
                is_res_d   = 1'b0;
                res_neg_d  = 1'b0;
                entry_d    = '0;
                cnt_d      = '0;
            end else if (is_digit) begin
                case (state_q)
                    ENTER_A: begin
                        if (cnt_q < MAX_CNT) begin
                            op_a_d  = op_a_append;
                            entry_d = {entry_q[2:0], key_code};
                            cnt_d   = cnt_q + 3'd1;
                        end else begin
                            key_err_d = 1'b1;
                        end
                    end
                    ENTER_B: begin
                        if (cnt_q < MAX_CNT) begin
                            op_b_d  = op_b_append;
                            entry_d = {entry_q[2:0], key_code};
                            cnt_d   = cnt_q + 3'd1;
                        end else begin
                            key_err_d = 1'b1;
                        end
                    end
                    SHOW_RES: begin
                        // A digit after a result starts a fresh calculation.
                        state_d   = ENTER_A;
                        op_a_d    = digit_ext;
                        op_b_d    = '0;
                        entry_d   = {12'd0, key_code};
                        cnt_d     = 3'd1;
                        is_res_d  = 1'b0;
                        res_neg_d = 1'b0;
                    end
                    default: ;
                endcase
            end else if (is_op) begin
                case (state_q)
                    ENTER_A: begin
                        state_d    = ENTER_B;
                        operator_d = op_is_plus;
                        op_b_d     = '0;
                        entry_d    = '0;
                        cnt_d      = '0;
                    end
                    ENTER_B: operator_d = op_is_plus;
                    SHOW_RES: begin
`ifdef CALC_CHAIN_EN
                        if (chain_ok) begin
                            state_d    = ENTER_B;
                            op_a_d     = chain_val[13:0];
                            operator_d = op_is_plus;
                            op_b_d     = '0;
                            entry_d    = '0;
                            cnt_d      = '0;
                            is_res_d   = 1'b0;
                            res_neg_d  = 1'b0;
                        end else begin
                            key_err_d = 1'b1;
                        end
`else
                        key_err_d = 1'b1;
`endif
                    end
                    default: ;
                endcase
            end else if (is_eq) begin
                case (state_q)
                    ENTER_A: key_err_d = 1'b1;
                    ENTER_B: begin
                        state_d   = SHOW_RES;
                        is_res_d  = 1'b1;
                        res_neg_d = !operator_q && (op_b_q > op_a_q);
                    end
                    default: ;
                endcase
            end else begin
                // Reserved codes 14 and 15.
                key_err_d = 1'b1;
            end
        end
    end

    // Output logic: outputs are straight views of the registered state.
    always_comb begin
        op_a_bin = op_a_q;
        op_b_bin = op_b_q;
        operator = operator_q;
        is_res   = is_res_q;
        entry_d3 = entry_q[3];
        entry_d2 = entry_q[2];
        entry_d1 = entry_q[1];
        entry_d0 = entry_q[0];
        res_neg  = res_neg_q;
        key_err  = key_err_q;
        state_o  = state_q;
    end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Testbench for calc_seq_ctrl: directed keypad sequences plus random keys.
// The driver updates a decimal-level calculator model and queues the outputs
// expected one cycle later; an independent monitor pops and compares them.
module tb_calc_seq_ctrl;

    localparam int MAXD = 4;

    logic        clk;
    logic        rst_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [13:0] op_a_bin;
    logic [13:0] op_b_bin;
    logic        operator;
    logic        is_res;
    logic [3:0]  entry_d3, entry_d2, entry_d1, entry_d0;
    logic        res_neg;
    logic        key_err;
    logic [1:0]  state_o;

    calc_seq_ctrl #(.MAX_DIGITS(MAXD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .op_a_bin  (op_a_bin),
        .op_b_bin  (op_b_bin),
        .operator  (operator),
        .is_res    (is_res),
        .entry_d3  (entry_d3),
        .entry_d2  (entry_d2),
        .entry_d1  (entry_d1),
        .entry_d0  (entry_d0),
        .res_neg   (res_neg),
        .key_err   (key_err),
        .state_o   (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int op;
        int isres;
        int d3, d2, d1, d0;
        int neg;
        int err;
        int st;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int issued   = 0;
    int committed = 0;
    int checked  = 0;
    int err_pulses = 0;

    // Calculator model: mode 0 = entering A, 1 = entering B, 2 = showing result.
    int m_state, m_a, m_b, m_op, m_cnt, m_isres, m_neg, m_err;

    task automatic check(input string name, input int act, input int want);
        n_checks++;
        if (act != want) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_a = 0; m_b = 0; m_op = 1; m_cnt = 0;
        m_isres = 0; m_neg = 0; m_err = 0;
    endtask

    task automatic model_key(input int code);
        int r;
        m_err = 0;
        if (code <= 9) begin
            if (m_state == 2) begin
                m_a = code; m_b = 0; m_cnt = 1; m_isres = 0; m_neg = 0; m_state = 0;
            end else if (m_cnt >= MAXD) begin
                m_err = 1;
            end else begin
                if (m_state == 0) m_a = m_a * 10 + code;
                else              m_b = m_b * 10 + code;
                m_cnt++;
            end
        end else if (code == 10 || code == 11) begin
            if (m_state == 0) begin
                m_op = (code == 10); m_state = 1; m_b = 0; m_cnt = 0;
            end else if (m_state == 1) begin
                m_op = (code == 10);
            end else begin
`ifdef CALC_CHAIN_EN
                r = m_op ? m_a + m_b : m_a - m_b;
                if (r >= 0 && r <= 9999) begin
                    m_a = r; m_op = (code == 10); m_b = 0; m_cnt = 0;
                    m_isres = 0; m_neg = 0; m_state = 1;
                end else begin
                    m_err = 1;
                end
`else
                r = 0;
                m_err = 1;
`endif
            end
        end else if (code == 12) begin
            if (m_state == 0) m_err = 1;
            else if (m_state == 1) begin
                m_state = 2; m_isres = 1; m_neg = (m_op == 0 && m_b > m_a);
            end
        end else if (code == 13) begin
            model_reset();
        end else begin
            m_err = 1;
        end
    endtask

    // Expected outputs: the display shows the operand being (or last) entered
    // in decimal -- A while entering A, B otherwise.
    function automatic exp_t snap();
        exp_t e;
        int v;
        v = (m_state == 0) ? m_a : m_b;
        e.a = m_a; e.b = m_b; e.op = m_op; e.isres = m_isres;
        e.d0 = v % 10; e.d1 = (v / 10) % 10; e.d2 = (v / 100) % 10; e.d3 = (v / 1000) % 10;
        e.neg = m_neg; e.err = m_err; e.st = m_state;
        return e;
    endfunction

    // One driven cycle: valid=0 is an idle cycle, which must still clear key_err.
    task automatic send(input bit valid, input int code);
        @(posedge clk);
        #1;
        key_valid = valid;
        key_code  = 4'(code);
        if (valid) model_key(code);
        else       m_err = 0;
        sb_q.push_back(snap());
        issued++;
    endtask

    task automatic keys(input int seq[$]);
        foreach (seq[i]) send(1'b1, seq[i]);
        send(1'b0, 0);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 50 && checked != issued; i++) @(negedge clk);
        check({tag, "_drain"}, checked, issued);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_op_a"},     int'(op_a_bin), 0);
        check({tag, "_op_b"},     int'(op_b_bin), 0);
        check({tag, "_operator"}, int'(operator), 1);
        check({tag, "_is_res"},   int'(is_res), 0);
        check({tag, "_entry"},    int'({entry_d3, entry_d2, entry_d1, entry_d0}), 0);
        check({tag, "_res_neg"},  int'(res_neg), 0);
        check({tag, "_key_err"},  int'(key_err), 0);
        check({tag, "_state"},    int'(state_o), 0);
    endtask

    // A queued expectation becomes due once the clock edge after its drive has passed.
    always @(posedge clk) committed <= issued;

    always @(negedge clk) err_pulses <= err_pulses + int'(key_err);

    // Monitor: compare DUT outputs with the oldest due expectation.
    always @(negedge clk) begin
        exp_t e;
        while (checked < committed) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 0, 1);
            end else begin
                e = sb_q.pop_front();
                check("op_a_bin", int'(op_a_bin), e.a);
                check("op_b_bin", int'(op_b_bin), e.b);
                check("operator", int'(operator), e.op);
                check("is_res",   int'(is_res),   e.isres);
                check("entry_d3", int'(entry_d3), e.d3);
                check("entry_d2", int'(entry_d2), e.d2);
                check("entry_d1", int'(entry_d1), e.d1);
                check("entry_d0", int'(entry_d0), e.d0);
                check("res_neg",  int'(res_neg),  e.neg);
                check("key_err",  int'(key_err),  e.err);
                check("state_o",  int'(state_o),  e.st);
            end
            checked++;
        end
    end

    initial begin
        int e0;
        int r;
        key_valid = 1'b0;
        key_code  = 4'd0;
        rst_n     = 1'b0;
        model_reset();
        #12;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        // 12 + 34 =
        keys('{1, 2, 10, 3, 4, 12});
        drain("add");
        check("add_op_a", int'(op_a_bin), 12);
        check("add_op_b", int'(op_b_bin), 34);
        check("add_operator", int'(operator), 1);
        check("add_is_res", int'(is_res), 1);
        check("add_state", int'(state_o), 2);
        check("add_res_neg", int'(res_neg), 0);

        // 5 - 9 = gives a negative flag, then 7 starts over.
        keys('{5, 11, 9, 12});
        drain("sub");
        check("sub_operator", int'(operator), 0);
        check("sub_res_neg", int'(res_neg), 1);
        keys('{7});
        drain("new");
        check("new_op_a", int'(op_a_bin), 7);
        check("new_is_res", int'(is_res), 0);
        check("new_entry", int'({entry_d3, entry_d2, entry_d1, entry_d0}), 16'h0007);
        check("new_state", int'(state_o), 0);

        // Digit overflow: fifth digit is rejected exactly once.
        keys('{13});
        drain("clr0");
        e0 = err_pulses;
        keys('{9, 9, 9, 9, 8});
        drain("full");
        check("full_op_a", int'(op_a_bin), 9999);
        check("full_entry", int'({entry_d3, entry_d2, entry_d1, entry_d0}), 16'h9999);
        check("full_err_pulses", err_pulses - e0, 1);

        // Clear mid-entry, then asynchronous reset mid-entry.
        keys('{4, 5, 10, 6, 13});
        drain("clr");
        check_reset_outputs("clr");
        keys('{4, 5, 10, 6});
        drain("pre_rst");
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("arst");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // '=' without an operator and a reserved code: two back-to-back errors.
        e0 = err_pulses;
        keys('{12, 15});
        drain("err");
        check("err_pulses", err_pulses - e0, 2);
        check("err_state", int'(state_o), 0);
        check("err_op_a", int'(op_a_bin), 0);

        // Operator after a result: chain or reject depending on the build.
        keys('{13, 2, 0, 10, 5, 12, 11});
        drain("chain");
`ifdef CALC_CHAIN_EN
        check("chain_state", int'(state_o), 1);
`else
        check("chain_state", int'(state_o), 2);
`endif
        keys('{3, 12});
        drain("chain2");
`ifdef CALC_CHAIN_EN
        check("chain_op_a", int'(op_a_bin), 25);
        check("chain_op_b", int'(op_b_bin), 3);
        check("chain_operator", int'(operator), 0);
`else
        check("chain_op_a", int'(op_a_bin), 3);
        check("chain_state2", int'(state_o), 0);
`endif

        // Random keys, weighted toward digits, with idle gaps.
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(99));
            if      (r < 55) send(1'b1, int'($urandom_range(9)));
            else if (r < 66) send(1'b1, 10);
            else if (r < 76) send(1'b1, 11);
            else if (r < 88) send(1'b1, 12);
            else if (r < 91) send(1'b1, 13);
            else if (r < 94) send(1'b1, 14 + int'($urandom_range(1)));
            else             send(1'b0, 0);
        end
        send(1'b0, 0);
        drain("rand");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
